k2red_ln_shift: RTL and testbench

- Pipelined double K-RED (K2-RED) modular reduction for Proth-form primes q = k*2^m + 1.
- k has a leading term plus up to two extra power-of-two terms, so every multiply by k is a shift-add.
- Input: a 2W-bit product A, typically the raw output of a W-bit multiplier in an NTT butterfly.
- Output: C2 = k^2*A mod q, fully reduced into [0, q).

---
 rtl/k2red_ln_shift.sv | 132 +++++++++++++
 tb/tb_k2red_ln_shift.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/k2red_ln_shift.sv
// Four-stage double K-RED reduction for Proth moduli q = k*2^m + 1 with shift-add k.
// C2 = k^2 * A mod q, fully reduced; modulus parameters travel with each operand.
module k2red_ln_shift #(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2*W-1:0]   A,
   input  logic [W-1:0]     Q,
   input  logic [5:0]       l1,
   input  logic [5:0]       l2,
   input  logic [5:0]       l3,
   input  logic [5:0]       m,
   output logic [W-1:0]     C2
);

   localparam int CW = 2*W + 2;   // first-reduction width, wide enough for any m
   localparam int DW = W + 3;     // second-reduction result, holds (-2q, 2q)
   localparam int RW = W + 4;     // headroom for the two-step correction

   // k*x as a shift-add; any l1 of 2 or more uses both extra terms
   function automatic logic [CW-1:0] mul_k(input logic [CW-1:0] x,
                                           input logic [5:0]    mm,
                                           input logic [5:0]    l1v,
                                           input logic [5:0]    l2v,
                                           input logic [5:0]    l3v);
      logic [CW-1:0] acc;
      logic [5:0]    lead;
      lead = 6'(W-1) - mm;
      acc  = x << lead;
      if (l1v >= 6'd1) acc = acc + (x << l2v);
      if (l1v >= 6'd2) acc = acc + (x << l3v);
      return acc;
   endfunction

   function automatic logic [CW-1:0] low_mask(input logic [5:0] mm);
      return (CW'(1) << mm) - CW'(1);
   endfunction

   // Fold a value in (-2q, 2q) into [0, q) with at most two adds or two subtracts
   function automatic logic [W-1:0] correct(input logic signed [DW-1:0] d,
                                            input logic [W-1:0]        qv);
      logic signed [RW-1:0] t;
      logic signed [RW-1:0] qs;
      qs = $signed({{(RW-W){1'b0}}, qv});
      t  = $signed({{(RW-DW){d[DW-1]}}, d});
      if (t < 0) begin
         t = t + qs;
         if (t < 0) t = t + qs;
      end else if (t >= qs) begin
         t = t - qs;
         if (t >= qs) t = t - qs;
      end
      return t[W-1:0];
   endfunction

   logic [CW-1:0]        a0_p0;
   logic [CW-1:0]        a1_p0;
   logic signed [CW-1:0] c1_p1_d, c1_p1_q;
   logic [W-1:0]         mod_p1_d, mod_p1_q;
   logic [5:0]           m_p1_d, m_p1_q;
   logic [5:0]           l1_p1_d, l1_p1_q;
   logic [5:0]           l2_p1_d, l2_p1_q;
   logic [5:0]           l3_p1_d, l3_p1_q;

   logic [CW-1:0]        b0_p1;
   logic signed [CW-1:0] b1_p1;
   logic signed [DW-1:0] d_p2_d, d_p2_q;
   logic [W-1:0]         mod_p2_d, mod_p2_q;

   logic [W-1:0]         r_p3_d, r_p3_q;
   logic [W-1:0]         c2_p4_d, c2_p4_q;

   // Stage 1: C1 = k*A0 - A1
   always_comb begin
      a0_p0    = {2'b00, A} & low_mask(m);
      a1_p0    = {2'b00, A >> m};
      c1_p1_d  = $signed(mul_k(a0_p0, m, l1, l2, l3) - a1_p0);
      mod_p1_d = Q;
      m_p1_d   = m;
      l1_p1_d  = l1;
      l2_p1_d  = l2;
      l3_p1_d  = l3;
   end

   // Stage 2: D = k*B0 - B1 with B1 taken by arithmetic shift of signed C1
   always_comb begin
      b0_p1    = $unsigned(c1_p1_q) & low_mask(m_p1_q);
      b1_p1    = c1_p1_q >>> m_p1_q;
      d_p2_d   = DW'($signed(mul_k(b0_p1, m_p1_q, l1_p1_q, l2_p1_q, l3_p1_q)) - b1_p1);
      mod_p2_d = mod_p1_q;
   end

   // Stage 3: final correction into [0, q)
   always_comb begin
      r_p3_d = correct(d_p2_q, mod_p2_q);
   end

   // Stage 4: output register
   always_comb begin
      c2_p4_d = r_p3_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c1_p1_q  <= '0;
         mod_p1_q <= '0;
         m_p1_q   <= '0;
         l1_p1_q  <= '0;
         l2_p1_q  <= '0;
         l3_p1_q  <= '0;
         d_p2_q   <= '0;
         mod_p2_q <= '0;
         r_p3_q   <= '0;
         c2_p4_q  <= '0;
      end else begin
         c1_p1_q  <= c1_p1_d;
         mod_p1_q <= mod_p1_d;
         m_p1_q   <= m_p1_d;
         l1_p1_q  <= l1_p1_d;
         l2_p1_q  <= l2_p1_d;
         l3_p1_q  <= l3_p1_d;
         d_p2_q   <= d_p2_d;
         mod_p2_q <= mod_p2_d;
         r_p3_q   <= r_p3_d;
         c2_p4_q  <= c2_p4_d;
      end
   end

   assign C2 = c2_p4_q;

endmodule

// File: tb/tb_k2red_ln_shift.sv
// Bench for k2red_ln_shift: directed vector table, hand-written pipeline sequences,
// and randomized streaming against a modular-arithmetic reference delay line.
module tb_k2red_ln_shift;

   logic        clk;
   logic        rst;
   logic [63:0] A;
   logic [31:0] Q;
   logic [5:0]  l1, l2, l3, m;
   logic [31:0] C2;

   int n_checks;
   int n_fail;

   logic [31:0] pv  [4];
   bit          pdc [4];

   typedef struct {
      logic [63:0] a;
      logic [31:0] q;
      logic [5:0]  l1, l2, l3, m;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [5:0]  l1, l2, l3, m;
   } cfg_t;

   vec_t vecs[$];
   cfg_t cfgs[4];

   localparam logic [31:0] Q0  = 32'd2148794369;
   localparam logic [63:0] BIG = 64'd2500883870215315764;

   k2red_ln_shift #(.W(32)) dut (
      .clk(clk), .rst(rst), .A(A), .Q(Q),
      .l1(l1), .l2(l2), .l3(l3), .m(m), .C2(C2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_red(input logic [63:0] a, input logic [31:0] q,
                                           input logic [5:0] l1v, input logic [5:0] l2v,
                                           input logic [5:0] l3v, input logic [5:0] mv);
      logic [127:0] k;
      k = 128'd1 << (31 - int'(mv));
      if (l1v >= 6'd1) k = k + (128'd1 << l2v);
      if (l1v >= 6'd2) k = k + (128'd1 << l3v);
      return 32'((k * k * {64'd0, a}) % {96'd0, q});
   endfunction

   task automatic model_step();
      logic [63:0] qq;
      qq = {32'd0, Q} * {32'd0, Q};
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pv[i]  = '0;
            pdc[i] = 1'b0;
         end
      end else begin
         for (int i = 3; i > 0; i--) begin
            pv[i]  = pv[i-1];
            pdc[i] = pdc[i-1];
         end
         pdc[0] = (A >= qq);
         pv[0]  = pdc[0] ? 32'd0 : ref_red(A, Q, l1, l2, l3, m);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] exp);
      n_checks++;
      if (C2 !== exp) begin
         n_fail++;
         $display("FAIL %s: C2=%0d expected %0d", name, C2, exp);
      end
   endtask

   task automatic set_cfg(input cfg_t c);
      Q  = c.q;
      l1 = c.l1;
      l2 = c.l2;
      l3 = c.l3;
      m  = c.m;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 4; i++) begin
         pv[i]  = '0;
         pdc[i] = 1'b0;
      end

      cfgs[0] = '{q: Q0,             l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17};
      cfgs[1] = '{q: Q0,             l1: 6'd7, l2: 6'd1, l3: 6'd3, m: 6'd17};
      cfgs[2] = '{q: 32'd2151677953, l1: 6'd1, l2: 6'd2, l3: 6'd5, m: 6'd20};
      cfgs[3] = '{q: 32'd2147483649, l1: 6'd0, l2: 6'd0, l3: 6'd1, m: 6'd24};

      vecs.push_back('{a: BIG,                                l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd1965696994});
      vecs.push_back('{a: 64'd1,                              l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd268763236});
      vecs.push_back('{a: 64'd0,                              l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd0});
      vecs.push_back('{a: {32'd0, Q0},                        l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd0});
      vecs.push_back('{a: {32'd0, Q0} - 64'd1,                l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd1880031133});
      vecs.push_back('{a: {32'd0, Q0} * 64'd2,                l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd0});
      vecs.push_back('{a: {32'd0, Q0} * {32'd0, Q0} - 64'd1,  l1: 6'd2, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd1880031133});
      vecs.push_back('{a: 64'd1,                              l1: 6'd7, l2: 6'd1, l3: 6'd3, m: 6'd17, q: Q0, exp: 32'd268763236});
      vecs.push_back('{a: 64'd1,                              l1: 6'd1, l2: 6'd2, l3: 6'd5, m: 6'd20, q: 32'd2151677953, exp: 32'd4210704});
      vecs.push_back('{a: 64'd1,                              l1: 6'd0, l2: 6'd0, l3: 6'd1, m: 6'd24, q: 32'd2147483649, exp: 32'd16384});
      vecs.push_back('{a: 64'd2147483648,                     l1: 6'd0, l2: 6'd0, l3: 6'd1, m: 6'd24, q: 32'd2147483649, exp: 32'd2147467265});

      // Reset with all inputs at zero, then a second single-cycle reset
      rst = 1'b1; A = '0; Q = '0; l1 = '0; l2 = '0; l3 = '0; m = '0;
      tick();
      tick();
      check("reset_c2", 32'd0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("reset_hold", 32'd0);
      rst = 1'b0;

      // Directed vector table, each held for the full latency
      foreach (vecs[i]) begin
         A = vecs[i].a; Q = vecs[i].q; m = vecs[i].m;
         l1 = vecs[i].l1; l2 = vecs[i].l2; l3 = vecs[i].l3;
         for (int c = 0; c < 4; c++) tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Flush to zero, then back-to-back operands
      set_cfg(cfgs[0]);
      A = '0;
      for (int c = 0; c < 4; c++) tick();
      check("flush", 32'd0);
      A = 64'd1;               tick();
      A = BIG;                 tick();
      A = {32'd0, Q0} - 64'd1; tick();
      check("b2b_not_early", 32'd0);
      A = '0;                  tick();
      check("b2b_0", 32'd268763236);
      tick();
      check("b2b_1", 32'd1965696994);
      tick();
      check("b2b_2", 32'd1880031133);
      tick();
      check("b2b_3", 32'd0);

      // Reset while operands are in flight, then refill
      A = 64'd1;               tick();
      A = BIG;                 tick();
      A = {32'd0, Q0} - 64'd1; tick();
      A = 64'd1;               tick();
      check("pre_rst", 32'd268763236);
      rst = 1'b1; A = BIG;     tick();
      check("mid_rst", 32'd0);
      rst = 1'b0; A = BIG;     tick();
      check("drain0", 32'd0);
      A = '0;                  tick();
      check("drain1", 32'd0);
      tick();
      check("drain2", 32'd0);
      tick();
      check("refill", 32'd1965696994);

      // Constant input keeps the output constant
      A = BIG;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c >= 3) check("stable", 32'd1965696994);
      end

      // Randomized streaming with per-operand configuration and sporadic reset
      for (int i = 0; i < 400; i++) begin
         logic [63:0] qq;
         int          sel;
         set_cfg(cfgs[$urandom_range(0, 3)]);
         qq  = {32'd0, Q} * {32'd0, Q};
         sel = int'($urandom_range(0, 19));
         case (sel)
            0:       A = '0;
            1:       A = {32'd0, Q} * {32'd0, 32'($urandom_range(0, 65535))};
            2:       A = {2'b11, 30'($urandom), $urandom};
            default: A = {$urandom, $urandom} % qq;
         endcase
         rst = ($urandom_range(0, 49) == 0);
         tick();
         if (!pdc[3]) check("rand", pv[3]);
      end
      rst = 1'b0;
      A   = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (!pdc[3]) check("rand_tail", pv[3]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
